// File: rtl/cordic_stim_pkg.sv
// Shared types and helpers for the CORDIC stimulus generator: FSM states,
// channel-index width and the triangle/square waveform folding functions.
package cordic_stim_pkg;

   localparam int MAX_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } stim_state_t;

   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   // Fold the top phase bits into a two's-complement triangle of width w.
   function automatic logic [MAX_W-1:0] tri_fold(input logic [MAX_W-1:0] u, input int w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] s;
      logic [MAX_W-1:0] f;
      mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((32'd1 << w) - 32'd1);
      s    = (u << 1) & mask;
      f    = u[w-1] ? (~s & mask) : s;
      return f ^ (32'd1 << (w - 1));
   endfunction

   function automatic logic [MAX_W-1:0] sqr_fold(input logic neg, input int amp);
      return neg ? 32'(-amp) : 32'(amp);
   endfunction

endpackage

// File: rtl/cordic_stim_gen_if.sv
// Beat stream of the CORDIC stimulus generator: valid/ready handshake plus
// per-beat channel index, angle, start vector and waveform samples.
interface cordic_stim_gen_if #(
   parameter int WIDTH = 16,
   parameter int CH_W  = 1
);
   logic             out_valid;
   logic             out_ready;
   logic [CH_W-1:0]  out_ch;
   logic [WIDTH-1:0] angle;
   logic [WIDTH-1:0] x_start;
   logic [WIDTH-1:0] y_start;
   logic [WIDTH-1:0] tri_amp;
   logic [WIDTH-1:0] sqr_amp;

   modport master (
      output out_valid, out_ch, angle, x_start, y_start, tri_amp, sqr_amp,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_ch, angle, x_start, y_start, tri_amp, sqr_amp,
      output out_ready
   );
endinterface

// File: rtl/cordic_stim_phase_acc.sv
// One channel's phase accumulator, advanced by its tuning word on each
// enabled sample tick and frozen otherwise.
module cordic_stim_phase_acc #(
   parameter int PHASE_W = 24
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               tick,
   input  logic               enable,
   input  logic [PHASE_W-1:0] freq,
   output logic [PHASE_W-1:0] phase
);
   logic [PHASE_W-1:0] r_phase;

   assign phase = r_phase;

   // Phase register; freq is only looked at on a tick.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_phase <= {PHASE_W{1'b0}};
      end else if (tick && enable) begin
         r_phase <= r_phase + freq;
      end else begin
         r_phase <= r_phase;
      end
   end
endmodule

// File: rtl/cordic_stim_gen.sv
// Multi-channel CORDIC stimulus generator: per sample tick, one beat per channel.
// Optional build macro CORDIC_STIM_PHASE_OFFSET_EN adds a per-channel phase_ofs input.
module cordic_stim_gen
   import cordic_stim_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int PHASE_W  = 24,
   parameter int CHANNELS = 2,
   parameter int DIV      = 4,
   parameter int X_INIT   = 1215,
   parameter int SQR_AMP  = 2000
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        enable,
   input  logic [CHANNELS*PHASE_W-1:0] freq_word,
`ifdef CORDIC_STIM_PHASE_OFFSET_EN
   input  logic [CHANNELS*PHASE_W-1:0] phase_ofs,
`endif
   output logic                        overrun,
   cordic_stim_gen_if.master           bus
);
   localparam int CH_W  = ch_width(CHANNELS);
   localparam int DIV_W = $clog2(DIV);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0]   r_div_cnt;
   logic               w_tick;
   logic [PHASE_W-1:0] w_phase [CHANNELS];
   logic [PHASE_W-1:0] w_phase0_next;

   stim_state_t        r_state;
   stim_state_t        w_state_nxt;
   logic               r_valid;
   logic               r_overrun;
   logic [CH_W-1:0]    r_ch;
   logic [CH_W-1:0]    w_ch_inc;
   logic [CH_W-1:0]    w_ld_ch;
   logic               w_load;
   logic               w_hs;
   logic [PHASE_W-1:0] w_src_phase;
   logic [PHASE_W-1:0] w_eff_phase;
   logic [WIDTH-1:0]   w_u;

   logic [WIDTH-1:0]   r_angle;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_tri;
   logic [WIDTH-1:0]   r_sqr;

   assign w_tick = enable && (r_div_cnt == DIV_LAST);

   // Sample-rate prescaler; holds its count while disabled.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_div_cnt <= {DIV_W{1'b0}};
      end else if (w_tick) begin
         r_div_cnt <= {DIV_W{1'b0}};
      end else if (enable) begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_acc
      cordic_stim_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
         .clock  (clock),
         .resetn (resetn),
         .tick   (w_tick),
         .enable (enable),
         .freq   (freq_word[c*PHASE_W +: PHASE_W]),
         .phase  (w_phase[c])
      );
   end

   // Channel 0 of a new burst sees the phase as it will be after this tick.
   assign w_phase0_next = w_phase[0] + freq_word[PHASE_W-1:0];
   assign w_ch_inc      = r_ch + 1'b1;
   assign w_hs          = r_valid && bus.out_ready;

   // Next-state and beat-load selection.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_ld_ch     = r_ch;
      w_src_phase = w_phase[r_ch];
      case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               w_state_nxt = ST_EMIT;
               w_load      = 1'b1;
               w_ld_ch     = {CH_W{1'b0}};
               w_src_phase = w_phase0_next;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (w_hs && (r_ch == LAST_CH)) begin
               w_state_nxt = ST_IDLE;
            end else if (w_hs) begin
               w_load      = 1'b1;
               w_ld_ch     = w_ch_inc;
               w_src_phase = w_phase[w_ch_inc];
            end else begin
               w_state_nxt = ST_EMIT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef CORDIC_STIM_PHASE_OFFSET_EN
   logic [PHASE_W-1:0] w_ofs [CHANNELS];
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ofs
      assign w_ofs[c] = phase_ofs[c*PHASE_W +: PHASE_W];
   end
   assign w_eff_phase = w_src_phase + w_ofs[w_ld_ch];
`else
   assign w_eff_phase = w_src_phase;
`endif

   assign w_u = WIDTH'(w_eff_phase >> (PHASE_W - WIDTH));

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered beat outputs, overrun flag and channel index.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_ch      <= {CH_W{1'b0}};
         r_angle   <= {WIDTH{1'b0}};
         r_x       <= {WIDTH{1'b0}};
         r_tri     <= {WIDTH{1'b0}};
         r_sqr     <= {WIDTH{1'b0}};
      end else begin
         r_valid   <= (w_state_nxt == ST_EMIT);
         r_overrun <= r_overrun | (w_tick && (r_state == ST_EMIT));
         if (w_load) begin
            r_ch    <= w_ld_ch;
            r_angle <= w_u;
            r_x     <= WIDTH'(X_INIT);
            r_tri   <= WIDTH'(tri_fold(MAX_W'(w_u), WIDTH));
            r_sqr   <= WIDTH'(sqr_fold(w_u[WIDTH-1], SQR_AMP));
         end
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.out_ch    = r_ch;
   assign bus.angle     = r_angle;
   assign bus.x_start   = r_x;
   assign bus.y_start   = {WIDTH{1'b0}};
   assign bus.tri_amp   = r_tri;
   assign bus.sqr_amp   = r_sqr;
   assign overrun       = r_overrun;
endmodule

// File: tb/tb_cordic_stim_gen.sv
// Self-checking bench for cordic_stim_gen: directed scenarios plus random
// stimulus, compared every cycle against a behavioural reference model.
module tb_cordic_stim_gen;
   localparam int WIDTH    = 16;
   localparam int PHASE_W  = 24;
   localparam int CHANNELS = 2;
   localparam int DIV      = 4;
   localparam int X_INIT   = 1215;
   localparam int SQR_AMP  = 2000;
   localparam int CH_W     = cordic_stim_pkg::ch_width(CHANNELS);
   localparam int HALF     = 1 << (WIDTH - 1);

   logic                        clock = 1'b0;
   logic                        resetn = 1'b0;
   logic                        enable = 1'b0;
   logic [CHANNELS*PHASE_W-1:0] freq_word = '0;
   logic                        overrun;
`ifdef CORDIC_STIM_PHASE_OFFSET_EN
   logic [CHANNELS*PHASE_W-1:0] phase_ofs = '0;
`endif

   cordic_stim_gen_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus_if ();

   cordic_stim_gen #(
      .WIDTH(WIDTH), .PHASE_W(PHASE_W), .CHANNELS(CHANNELS),
      .DIV(DIV), .X_INIT(X_INIT), .SQR_AMP(SQR_AMP)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .enable    (enable),
      .freq_word (freq_word),
`ifdef CORDIC_STIM_PHASE_OFFSET_EN
      .phase_ofs (phase_ofs),
`endif
      .overrun   (overrun),
      .bus       (bus_if.master)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [PHASE_W-1:0] m_ph [CHANNELS];
   int                 m_presc;
   bit                 m_busy;
   bit                 m_ovr;
   int                 m_ch;
   logic [WIDTH-1:0]   m_angle, m_x, m_y, m_tri, m_sqr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_triangle(input int u);
      int t;
      t = (u < HALF) ? (2 * u - HALF) : ((3 * HALF - 1) - 2 * u);
      return WIDTH'(t);
   endfunction

   task automatic model_load(input int ch, input logic [PHASE_W-1:0] p);
      int u;
      u       = int'(p >> (PHASE_W - WIDTH));
      m_ch    = ch;
      m_angle = WIDTH'(u);
      m_x     = WIDTH'(X_INIT);
      m_y     = '0;
      m_tri   = ref_triangle(u);
      m_sqr   = (u >= HALF) ? WIDTH'(-SQR_AMP) : WIDTH'(SQR_AMP);
   endtask

   task automatic model_update();
      logic [PHASE_W-1:0] nph [CHANNELS];
      bit tick;
      if (!resetn) begin
         for (int c = 0; c < CHANNELS; c++) m_ph[c] = '0;
         m_presc = 0; m_busy = 0; m_ovr = 0; m_ch = 0;
         m_angle = '0; m_x = '0; m_y = '0; m_tri = '0; m_sqr = '0;
      end else begin
         tick = enable && (m_presc == DIV - 1);
         if (enable) m_presc = (m_presc + 1) % DIV;
         for (int c = 0; c < CHANNELS; c++)
            nph[c] = tick ? m_ph[c] + freq_word[c*PHASE_W +: PHASE_W] : m_ph[c];
         if (!m_busy) begin
            if (tick) begin
               m_busy = 1;
               model_load(0, nph[0]);
            end
         end else begin
            if (tick) m_ovr = 1;
            if (bus_if.out_ready) begin
               if (m_ch == CHANNELS - 1) m_busy = 0;
               else model_load(m_ch + 1, m_ph[m_ch + 1]);
            end
         end
         for (int c = 0; c < CHANNELS; c++) m_ph[c] = nph[c];
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(bus_if.out_valid), 32'(m_busy));
      chk("overrun",   32'(overrun),          32'(m_ovr));
      chk("out_ch",    32'(bus_if.out_ch),    32'(m_ch));
      chk("angle",     32'(bus_if.angle),     32'(m_angle));
      chk("x_start",   32'(bus_if.x_start),   32'(m_x));
      chk("y_start",   32'(bus_if.y_start),   32'(m_y));
      chk("tri_amp",   32'(bus_if.tri_amp),   32'(m_tri));
      chk("sqr_amp",   32'(bus_if.sqr_amp),   32'(m_sqr));
   endtask

   // One clock: check current outputs, advance model with current inputs.
   task automatic step(input bit do_check);
      if (do_check) check_outputs();
      model_update();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset(input int n);
      resetn = 1'b0;
      for (int i = 0; i < n; i++) step(1'b1);
      resetn = 1'b1;
   endtask

   task automatic wait_beat(input string tag, input int ch, input int ang,
                            input bit chk_wave, input int trv, input int sqv);
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus_if.out_valid && bus_if.out_ready) found = 1;
         else step(1'b1);
      end
      chk({tag, "_found"}, 32'(found), 32'd1);
      if (found) begin
         chk({tag, "_ch"},    32'(bus_if.out_ch), 32'(ch));
         chk({tag, "_angle"}, 32'(bus_if.angle),  32'(ang));
         if (chk_wave) begin
            chk({tag, "_tri"}, 32'(bus_if.tri_amp), 32'(trv));
            chk({tag, "_sqr"}, 32'(bus_if.sqr_amp), 32'(sqv));
         end
         step(1'b1);
      end
   endtask

   initial begin
      bit found;
      bus_if.out_ready = 1'b1;

      // 1. reset
      resetn = 1'b0;
      step(1'b0);
      do_reset(3);
      chk("rst_valid",   32'(bus_if.out_valid), 32'd0);
      chk("rst_overrun", 32'(overrun),          32'd0);
      chk("rst_x",       32'(bus_if.x_start),   32'd0);

      // 2. basic bursts
      freq_word = {24'h020000, 24'h010000};
      enable = 1'b1;
      wait_beat("b1c0", 0, 16'h0100, 1'b0, 0, 0);
      wait_beat("b1c1", 1, 16'h0200, 1'b0, 0, 0);
      wait_beat("b2c0", 0, 16'h0200, 1'b0, 0, 0);
      wait_beat("b2c1", 1, 16'h0400, 1'b0, 0, 0);

      // 3. waveform quadrants
      do_reset(1);
      freq_word = {24'h000000, 24'h400000};
      wait_beat("q1", 0, 16'h4000, 1'b1, 16'h0000, 16'h07D0);
      wait_beat("q1b", 1, 16'h0000, 1'b1, 16'h8000, 16'h07D0);
      wait_beat("q2", 0, 16'h8000, 1'b1, 16'h7FFF, 16'hF830);
      wait_beat("q2b", 1, 16'h0000, 1'b0, 0, 0);
      wait_beat("q3", 0, 16'hC000, 1'b1, 16'hFFFF, 16'hF830);
      wait_beat("q3b", 1, 16'h0000, 1'b0, 0, 0);
      wait_beat("q4", 0, 16'h0000, 1'b1, 16'h8000, 16'h07D0);

      // 4. back-pressure mid-burst
      do_reset(1);
      freq_word = {24'h020000, 24'h010000};
      bus_if.out_ready = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus_if.out_valid) found = 1;
         else step(1'b1);
      end
      chk("stall_found", 32'(found), 32'd1);
      for (int i = 0; i < 10; i++) step(1'b1);
      chk("stall_overrun", 32'(overrun), 32'd1);
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b1);

      // 5. wrap-around and enable freeze
      do_reset(1);
      freq_word = {24'h000000, 24'hFFFFFF};
      wait_beat("wrap1", 0, 16'hFFFF, 1'b0, 0, 0);
      wait_beat("wrap1b", 1, 16'h0000, 1'b0, 0, 0);
      wait_beat("wrap2", 0, 16'hFFFF, 1'b0, 0, 0);
      for (int i = 0; i < 8; i++) step(1'b1);
      enable = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1);
      chk("frozen_valid", 32'(bus_if.out_valid), 32'd0);
      enable = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b1);

      // 6. reset while emitting channel 1
      freq_word = {24'h000100, 24'h123456};
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus_if.out_valid && bus_if.out_ch == 1'b1) found = 1;
         else step(1'b1);
      end
      chk("ch1_found", 32'(found), 32'd1);
      do_reset(1);
      chk("midrst_valid", 32'(bus_if.out_valid), 32'd0);
      wait_beat("post_rst", 0, 16'h1234, 1'b0, 0, 0);

      // random stimulus
      do_reset(2);
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) freq_word = {24'($urandom), 24'($urandom)};
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         enable = ($urandom_range(0, 7) != 0);
         step(1'b1);
      end
      check_outputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
